// File: rtl/z80_pkg.sv
// Shared Z80 core definitions: LD (nn),IX/IY sequencer states and opcode constants.
package z80_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } ld_st_t;

  localparam logic [7:0] OP_PREFIX_IX    = 8'hDD;
  localparam logic [7:0] OP_PREFIX_IY    = 8'hFD;
  localparam logic [7:0] OP_LD_IND_NN_RR = 8'h22;
  localparam int         LD_IND_NN_LEN   = 4;

endpackage

// File: rtl/z80_bus_cycle.sv
// Memory bus cycle driver: registered req/wr/addr/wdata held until the ack edge,
// plus completion and read-capture strobes for the owning sequencer.
module z80_bus_cycle (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        launch,
  input  logic        launch_wr,
  input  logic [15:0] launch_addr,
  input  logic [7:0]  launch_wdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        cyc_done,
  output logic        rd_strobe
);

  // Acks arriving with no request outstanding never complete anything.
  assign cyc_done  = bus_req & bus_ack;
  assign rd_strobe = cyc_done & ~bus_wr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
    end else if (launch) begin
      bus_req   <= 1'b1;
      bus_wr    <= launch_wr;
      bus_addr  <= launch_addr;
      bus_wdata <= launch_wdata;
    end else if (cyc_done) begin
      bus_req   <= 1'b0;
    end
  end

endmodule

// File: rtl/z80_ld_ind_nn_ixiy_exec.sv
// LD (nn),IX / LD (nn),IY execution sequencer: fetch nn from the instruction
// stream, store the index register little-endian at nn/nn+1, then retire.
module z80_ld_ind_nn_ixiy_exec
  import z80_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        iy,
  input  logic [15:0] ip_in,
  input  logic [15:0] ix_in,
  input  logic [15:0] iy_in,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        done,
  output logic [15:0] ip_out,
  output logic [15:0] fi_mem_waddr,
  output logic [7:0]  fi_mem_wdata,
  output logic [15:0] fi_mem_waddr2,
  output logic [7:0]  fi_mem_wdata2
);

  ld_st_t      state, state_nx;
  logic [15:0] ip_lat, reg_lat;
  logic [7:0]  nn_lo, nn_hi;
  logic [15:0] nn;
  logic        launch, launch_wr;
  logic [15:0] launch_addr;
  logic [7:0]  launch_wdata;
  logic        cyc_done, rd_strobe;

  assign nn   = {nn_hi, nn_lo};
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next bus cycle is launched on the same edge that completes the current
  // one, so req stays high across back-to-back cycles.
  always_comb begin
    state_nx     = state;
    launch       = 1'b0;
    launch_wr    = 1'b0;
    launch_addr  = 16'h0000;
    launch_wdata = 8'h00;
    unique case (state)
      IDLE: if (start) begin
        state_nx    = RD_LO;
        launch      = 1'b1;
        launch_addr = ip_in + 16'd2;
      end
      RD_LO: if (cyc_done) begin
        state_nx    = RD_HI;
        launch      = 1'b1;
        launch_addr = ip_lat + 16'd3;
      end
      RD_HI: if (cyc_done) begin
        state_nx     = WR_LO;
        launch       = 1'b1;
        launch_wr    = 1'b1;
        launch_addr  = {bus_rdata, nn_lo};
        launch_wdata = reg_lat[7:0];
      end
      WR_LO: if (cyc_done) begin
        state_nx     = WR_HI;
        launch       = 1'b1;
        launch_wr    = 1'b1;
        launch_addr  = nn + 16'd1;
        launch_wdata = reg_lat[15:8];
      end
      WR_HI: if (cyc_done) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latches: loaded only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ip_lat  <= ip_in;
      reg_lat <= iy ? iy_in : ix_in;
    end
    if (rd_strobe && state == RD_LO) nn_lo <= bus_rdata;
    if (rd_strobe && state == RD_HI) nn_hi <= bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ip_out        <= 16'h0000;
      fi_mem_waddr  <= 16'h0000;
      fi_mem_wdata  <= 8'h00;
      fi_mem_waddr2 <= 16'h0000;
      fi_mem_wdata2 <= 8'h00;
    end else if (state == WR_HI && cyc_done) begin
      ip_out        <= ip_lat + 16'(LD_IND_NN_LEN);
      fi_mem_waddr  <= nn;
      fi_mem_wdata  <= reg_lat[7:0];
      fi_mem_waddr2 <= nn + 16'd1;
      fi_mem_wdata2 <= reg_lat[15:8];
    end
  end

  z80_bus_cycle u_bus (
    .clk          (clk),
    .reset_n      (reset_n),
    .launch       (launch),
    .launch_wr    (launch_wr),
    .launch_addr  (launch_addr),
    .launch_wdata (launch_wdata),
    .bus_ack      (bus_ack),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .cyc_done     (cyc_done),
    .rd_strobe    (rd_strobe)
  );

endmodule

// File: doc/z80_ld_ind_nn_ixiy_exec.md
# z80_ld_ind_nn_ixiy_exec

Execution sequencer for the Z80 store instruction LD (nn),IX / LD (nn),IY (opcode DD 22 n n / FD 22 n n). After decode hands it the prefix/opcode context, it fetches the two immediate address bytes from the instruction stream. It then writes the selected index register to memory little-endian: low byte to nn, high byte to nn+1. It sits between the core's decode stage and the shared memory bus port. It produces a retirement record that the formal instruction spec for this opcode checks.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to execute; honoured only in IDLE
- iy  in  1  0 = store IX, 1 = store IY (prefix bit 5: DD→0, FD→1)
- ip_in  in  16  address of the DD/FD prefix byte
- ix_in  in  16  current IX
- iy_in  in  16  current IY
- busy  out  1  high in every state except IDLE
- bus_req  out  1  memory cycle request
- bus_wr  out  1  1 = write cycle, 0 = read cycle; valid while bus_req
- bus_addr  out  16  cycle address; valid while bus_req
- bus_wdata  out  8  write data; valid while bus_req && bus_wr
- bus_rdata  in  8  read data; sampled on the edge where bus_ack is high in a read cycle
- bus_ack  in  1  cycle completes on the edge where bus_req && bus_ack
- done  out  1  one-cycle retirement pulse
- ip_out  out  16  ip_in + 4, valid with done
- fi_mem_waddr  out  16  first write address (nn), valid with done
- fi_mem_wdata  out  8  first write data (register low byte), valid with done
- fi_mem_waddr2  out  16  second write address (nn+1), valid with done
- fi_mem_wdata2  out  8  second write data (register high byte), valid with done

## Operation
- Reset (reset_n low at an edge): state IDLE. All outputs 0, including busy, bus_req, done and all address/data/record outputs.
- IDLE: on start, latch iy, ip_in, and the selected register (iy ? iy_in : ix_in) into internal registers, then go to RD_LO. start while busy is ignored; latched operands do not change.
- RD_LO: read at ip+2. On ack, store bus_rdata as nn[7:0]. → RD_HI.
- RD_HI: read at ip+3. On ack, store bus_rdata as nn[15:8]. → WR_LO.
- WR_LO: write reg[7:0] to nn. On ack → WR_HI.
- WR_HI: write reg[15:8] to nn+1. On ack → DONE.
- DONE: done=1 for exactly one cycle; ip_out and fi_* outputs valid. → IDLE.
- Arithmetic: all address sums are modulo 2^16.
  - ip=FFFE reads FFFF? No: ip+2 = 0000, ip+3 = 0001.
  - nn=FFFF: second write goes to 0000.
  - ip_out = ip+4, wrapping.
- Registers are never modified by this block. The caller commits ip_out on done.
- bus_ack while bus_req is low is ignored.
- Reset mid-instruction: return to IDLE with no done pulse. A write already acknowledged is not undone.

## Timing
- bus_req, bus_wr, bus_addr and bus_wdata are registered and held stable from cycle entry until the ack edge.
- Back-to-back cycles: bus_req stays high. The next cycle's address and data appear in the cycle after the ack edge.
- Zero-wait latency:
  - start sampled at edge 0.
  - RD_LO during cycle 1, RD_HI cycle 2, WR_LO cycle 3, WR_HI cycle 4.
  - done high in cycle 5; busy low in cycle 6.
  - Minimum start→done is 5 cycles; each wait cycle adds 1.
- A new start is accepted in the first IDLE cycle after done.
- fi_* and ip_out hold their values after done until the next DONE. done itself is a single-cycle pulse.

## Structure
- Shared package z80_pkg holds:
  - state typedef ld_st_t: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE
  - constants OP_PREFIX_IX=8'hDD, OP_PREFIX_IY=8'hFD, OP_LD_IND_NN_RR=8'h22, LD_IND_NN_LEN=4
- One natural sub-module: z80_bus_cycle. It owns the req/wr/addr/wdata registers, hold-until-ack behaviour, and the rdata capture strobe. It is reusable by the read-direction sequencers.

## Test plan
- IX store, zero wait: ip=1000, ix=BEEF; memory 1002=34, 1003=12 → writes 1234←EF, 1235←BE; done in cycle 5; ip_out=1004; fi_* = 1234/EF/1235/BE.
- IY store with 2 wait cycles on every bus cycle: iy=A55A, nn=4000 → same write sequence; done in cycle 13; bus_addr/bus_wdata stable throughout each wait.
- Wrap-around: ip=FFFE, nn=FFFF → reads at 0000 and 0001; writes FFFF←lo and 0000←hi; ip_out=0002.
- start pulsed while busy, with different iy/ix values → ignored; the original operands are written; exactly one done.
- reset_n low during WR_HI wait → next cycle: state IDLE, bus_req=0, done never asserted. A fresh start then completes normally.
